// File: rtl/lsu_v1.sv
// Load/store initiator: turns one byte/half/word core access into memory_v2 word strobes,
// using read-modify-write for sub-word stores and sign/zero extension for loads.
module lsu_v1 #(
    parameter int addr_width = 10,
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_data_out,
    input  logic [data_width-1:0] mem_data_in,
    output logic                  mem_write_enable,
    output logic                  mem_read_enable
);

    // Handshake: a request is taken on an edge where req_valid and req_ready are both 1;
    // resp_valid is a one-cycle pulse and resp_err/resp_rdata are meaningful only with it.
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [15:0]           wdata_q, wdata_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic [addr_width-1:0] mem_addr_q, mem_addr_d;
    logic [data_width-1:0] mem_data_out_q, mem_data_out_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_re_q, mem_re_d;

    logic                  req_err;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [31:0]           load_ext;
    logic [data_width-1:0] merged;

    assign req_err = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (|req_addr[1:0]))
                   | ((req_addr >> (addr_width + 2)) != 32'd0);

    always_comb begin
        lane_b = mem_data_in[{addr_lo_q, 3'b000} +: 8];
        lane_h = mem_data_in[{addr_lo_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & lane_b[7]}}, lane_b};
            2'b01:   load_ext = {{16{~uns_q & lane_h[15]}}, lane_h};
            default: load_ext = mem_data_in;
        endcase
        // Unselected lanes keep the word just read from memory.
        merged = mem_data_in;
        if (size_q == 2'b00) merged[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
        else                 merged[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q;
    end

    always_comb begin
        state_d        = state_q;
        we_d           = we_q;
        size_d         = size_q;
        uns_d          = uns_q;
        addr_lo_d      = addr_lo_q;
        wdata_d        = wdata_q;
        req_ready_d    = 1'b0;
        resp_valid_d   = 1'b0;
        resp_err_d     = 1'b0;
        resp_rdata_d   = resp_rdata_q;
        mem_addr_d     = mem_addr_q;
        mem_data_out_d = mem_data_out_q;
        mem_we_d       = 1'b0;
        mem_re_d       = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    req_ready_d  = 1'b0;
                    we_d         = req_we;
                    size_d       = req_size;
                    uns_d        = req_unsigned;
                    addr_lo_d    = req_addr[1:0];
                    wdata_d      = req_wdata[15:0];
                    mem_addr_d   = req_addr[addr_width+1:2];
                    resp_rdata_d = 32'd0;
                    if (req_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_we && req_size == 2'b10) begin
                        state_d        = WR;
                        mem_we_d       = 1'b1;
                        mem_data_out_d = req_wdata;
                    end else begin
                        state_d  = RD;
                        mem_re_d = 1'b1;
                    end
                end
            end
            RD: state_d = CAP;
            CAP: begin
                if (we_q) begin
                    state_d        = WR;
                    mem_we_d       = 1'b1;
                    mem_data_out_d = merged;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_ext;
                end
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            we_q           <= 1'b0;
            size_q         <= 2'b00;
            uns_q          <= 1'b0;
            addr_lo_q      <= 2'b00;
            wdata_q        <= 16'd0;
            req_ready_q    <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= 32'd0;
            resp_err_q     <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_out_q <= '0;
            mem_we_q       <= 1'b0;
            mem_re_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            we_q           <= we_d;
            size_q         <= size_d;
            uns_q          <= uns_d;
            addr_lo_q      <= addr_lo_d;
            wdata_q        <= wdata_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_err_q     <= resp_err_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_out_q <= mem_data_out_d;
            mem_we_q       <= mem_we_d;
            mem_re_q       <= mem_re_d;
        end
    end

    assign req_ready        = req_ready_q;
    assign resp_valid       = resp_valid_q;
    assign resp_rdata       = resp_rdata_q;
    assign resp_err         = resp_err_q;
    assign mem_addr         = mem_addr_q;
    assign mem_data_out     = mem_data_out_q;
    assign mem_write_enable = mem_we_q;
    assign mem_read_enable  = mem_re_q;

endmodule

// File: doc/lsu_v1.md
# lsu_v1

Load/store initiator between the core's execute stage and `memory_v2`. It accepts one byte, halfword or word access at a time from the core over a valid/ready request and single-cycle response handshake. It translates each access into word-wide `memory_v2` read and write strobes, using read-modify-write for sub-word stores and sign/zero extension for loads. Misaligned and out-of-range accesses are rejected without touching memory.

## Interface
Parameters:
- addr_width, 10, word-address width of `memory_v2`
- data_width, 32, memory word width; only 32 is supported

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  synchronous, active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  block is idle and accepts a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  single-cycle pulse: access complete
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid: misaligned, illegal size or out of range
- mem_addr  out  addr_width  word address, equal to req_addr[addr_width+1:2]
- mem_data_out  out  data_width  write data driven to `memory_v2` data_in
- mem_data_in  in  data_width  read data from `memory_v2` data_out
- mem_write_enable  out  1  memory write strobe
- mem_read_enable  out  1  memory read strobe

## Operation
- All outputs are registered (Moore). States are IDLE, RD, CAP, WR, RESP.
- IDLE: req_ready=1. A handshake occurs when req_valid and req_ready are both 1. On a handshake, latch we, size, unsigned, addr and wdata.
- Error check on the latched request:
  - size=11 is an error.
  - half with addr[0]=1 is an error.
  - word with addr[1:0]≠00 is an error.
  - any bit of addr[31:addr_width+2] set is an error.
  - An error goes straight to RESP with resp_err=1 and no memory strobe.
- Transitions out of IDLE on a handshake: word store goes to WR; load or sub-word store goes to RD.
- RD: mem_read_enable=1 and mem_addr valid, for one cycle. Next state is CAP.
- CAP: sample mem_data_in.
  - Load: select the lane, extend, register into resp_rdata, then go to RESP.
  - Store: merge the lane into the sampled word, then go to WR.
- Lanes are little-endian.
  - Byte n (n = addr[1:0]) is bits [8n+7:8n].
  - Half h (h = addr[1]) is bits [16h+15:16h].
  - Unselected bytes of a merged store keep the sampled memory value.
- WR: mem_write_enable=1 with mem_data_out = merged word (or req_wdata for a word store), for one cycle. Next state is RESP.
- RESP: resp_valid=1 for one cycle, then IDLE.
- mem_read_enable and mem_write_enable are never both 1. mem_addr is held constant from RD/WR entry until RESP exits.
- Only one access is outstanding at a time. req_ready=0 in every state except IDLE.

## Timing
- `memory_v2` read latency: mem_data_in is valid on the cycle after the mem_read_enable cycle.
- With a handshake at edge T:
  - word store: WR at T+1, resp_valid at T+2
  - load and sub-word store: RD at T+1, CAP at T+2, and either resp_valid at T+3 (load) or WR at T+3 then resp_valid at T+4 (sub-word store)
  - error: resp_valid at T+1
- Back-to-back: req_ready returns in the cycle after resp_valid, so the next handshake is possible at the earliest 1 cycle after RESP.
- Reset (rst=0 sampled at an edge) leaves the block in IDLE after that edge with these values:
  - req_ready=0 while rst=0, and 1 on the first cycle after rst returns to 1
  - resp_valid=0, resp_err=0, resp_rdata=0
  - mem_read_enable=0, mem_write_enable=0, mem_addr=0, mem_data_out=0
- Reset mid-operation abandons the access. No strobe is issued after the reset edge and no response is produced. A write already strobed before reset is not undone.
- req_valid while req_ready=0 is ignored; the core must hold it.

## Test plan
- Word store then load: store 0xDEADBEEF at addr 0x010, then load word from 0x010. Required: one write strobe with mem_addr=4; load returns 0xDEADBEEF, resp_err=0, 3 cycles after the load handshake.
- Byte RMW: memory word 4 = 0x11223344; store byte 0xAA at 0x012. Required: RD then WR with mem_data_out=0x11AA3344; response 4 cycles after the handshake.
- Extension: word 4 = 0x80F0_7F01.
  - signed byte load at 0x011 gives 0x0000007F
  - signed byte load at 0x013 gives 0xFFFFFF80
  - signed half load at 0x012 gives 0xFFFF80F0
  - unsigned half load at 0x012 gives 0x000080F0
- Errors: none of these cases produces a memory strobe, and each gives resp_valid at T+1 with resp_err=1 and resp_rdata=0.
  - word load at 0x002
  - half store at 0x001
  - size=11
  - address 0x1000 with addr_width=10
- Reset mid-op: assert rst=0 during CAP of a byte store. Required: no mem_write_enable, no resp_valid, all outputs 0, and req_ready=1 the cycle after rst=1.
- Back-to-back: hold req_valid with alternating store/load requests. Required: each handshake falls exactly 1 cycle after the previous resp_valid, and strobes are never overlapped.
